scan_misr_reg: RTL and testbench

- Parametrised successor to the single-bit DFF/DFFSR cells: a WIDTH-bit register bank for fault-test work.
- Four modes: hold, parallel load, scan shift, and MISR signature compaction.
- Sits on each test partition boundary. Test logic chains banks through SI/SO and reads signatures from Q.
- Adds a shift-length counter with a one-cycle SHIFT_DONE pulse.

---
 rtl/scan_misr_reg_pkg.sv | 13 +
 rtl/scan_misr_reg_if.sv | 22 ++
 rtl/scan_misr_reg_counter.sv | 47 ++++
 rtl/scan_misr_reg.sv | 59 +++++
 tb/tb_scan_misr_reg.sv | 126 ++++++++++++
 5 files changed

// File: rtl/scan_misr_reg_pkg.sv
// Shared mode encodings and default MISR polynomial for the scan/MISR register bank.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_MISR  = 2'b11
    } scan_mode_t;

    localparam logic [7:0] DEFAULT_POLY = 8'h1D;

endpackage

// File: rtl/scan_misr_reg_if.sv
// Control/data bundle of one scan/MISR register bank; test logic drives via master.
interface scan_misr_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             EN;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             SHIFT_DONE;

    modport master (
        output EN, MODE, D, SI,
        input  Q, SO, SHIFT_DONE
    );

    modport slave (
        input  EN, MODE, D, SI,
        output Q, SO, SHIFT_DONE
    );
endinterface

// File: rtl/scan_misr_reg_counter.sv
// Shift-length counter: counts shift edges and emits a registered one-cycle pulse
// on the edge that completes a full WIDTH-bit shift.
module scan_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cnt_en,
    input  logic clr,
    output logic done
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (cnt_en) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (clr) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
endmodule

// File: rtl/scan_misr_reg.sv
// WIDTH-bit hold/load/scan/MISR register bank with shift-length done pulse.
// MISR compaction in MODE 11 is built only when SCAN_MISR_EN is defined; otherwise MODE 11 holds.
module scan_misr_reg
    import scan_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(DEFAULT_POLY)
) (
    input  logic              C,
    input  logic              R,
    scan_misr_reg_if.slave    bus
);
    logic [WIDTH-1:0] q_q, q_d;
    scan_mode_t       mode;
    logic             shift_en;
    logic             cnt_clr;

    assign mode = scan_mode_t'(bus.MODE);

    always_comb begin
        q_d = q_q;
        if (bus.EN) begin
            case (mode)
                MODE_LOAD:  q_d = bus.D;
                MODE_SHIFT: q_d = {q_q[WIDTH-2:0], bus.SI};
`ifdef SCAN_MISR_EN
                MODE_MISR:  q_d = ({q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0)) ^ bus.D;
`endif
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (!R) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign shift_en = (mode == MODE_SHIFT);
    assign cnt_clr  = !shift_en;

    scan_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (C),
        .rst_n  (R),
        .en     (bus.EN),
        .cnt_en (shift_en),
        .clr    (cnt_clr),
        .done   (bus.SHIFT_DONE)
    );

    assign bus.Q  = q_q;
    assign bus.SO = q_q[WIDTH-1];
endmodule

// File: tb/tb_scan_misr_reg.sv
// Directed-vector bench for scan_misr_reg (WIDTH=8, POLY=8'h1D, RESET_VAL=8'h00).
module tb_scan_misr_reg;
    logic C = 1'b0;
    logic R;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 C = ~C;

    scan_misr_reg_if #(.WIDTH(8)) bus ();

    scan_misr_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .POLY      (8'h1D)
    ) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic shifts(input int unsigned n, input int unsigned pulse_at, input string tag);
        for (int unsigned i = 1; i <= n; i++) begin
            step();
            chk(tag, 32'(bus.SHIFT_DONE), 32'(i == pulse_at));
        end
    endtask

    logic [7:0] pat;
    logic [7:0] misr_exp [9];

    initial begin
        R = 1'b0; bus.EN = 1'b1; bus.MODE = 2'b01; bus.D = 8'hFF; bus.SI = 1'b0;
        step();
        chk("rst_q", 32'(bus.Q), 32'h00);
        chk("rst_so", 32'(bus.SO), 32'h0);
        chk("rst_done", 32'(bus.SHIFT_DONE), 32'h0);

        R = 1'b1; bus.D = 8'hA5;
        step();
        chk("load_q", 32'(bus.Q), 32'hA5);
        chk("load_so", 32'(bus.SO), 32'h1);

        bus.MODE = 2'b00; bus.D = 8'h3C;
        for (int i = 0; i < 3; i++) begin step(); chk("hold_q", 32'(bus.Q), 32'hA5); end
        bus.EN = 1'b0; bus.MODE = 2'b01;
        for (int i = 0; i < 3; i++) begin step(); chk("en0_q", 32'(bus.Q), 32'hA5); end

        // full shift out of A5, then a second back-to-back window
        bus.EN = 1'b1; bus.MODE = 2'b10; bus.SI = 1'b0; pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("so_seq", 32'(bus.SO), 32'(pat[7-i]));
            step();
            chk("full_done", 32'(bus.SHIFT_DONE), 32'(i == 7));
        end
        chk("full_q", 32'(bus.Q), 32'h00);
        bus.SI = 1'b1;
        shifts(8, 8, "b2b_done");
        chk("b2b_q", 32'(bus.Q), 32'hFF);

        bus.MODE = 2'b00;
        step();
        chk("idle_done", 32'(bus.SHIFT_DONE), 32'h0);

        // partial shift broken by hold never completes
        bus.MODE = 2'b10; bus.SI = 1'b0;
        shifts(5, 0, "part_done");
        bus.MODE = 2'b00;
        step();
        chk("break_done", 32'(bus.SHIFT_DONE), 32'h0);
        bus.MODE = 2'b10;
        shifts(8, 8, "resume_done");

        // reset injected on the 4th shift edge
        bus.SI = 1'b1;
        shifts(3, 0, "pre_rst_done");
        chk("pre_rst_q", 32'(bus.Q), 32'h07);
        R = 1'b0;
        step();
        chk("mid_rst_q", 32'(bus.Q), 32'h00);
        chk("mid_rst_done", 32'(bus.SHIFT_DONE), 32'h0);
        R = 1'b1;
        shifts(8, 8, "post_rst_done");

        // EN=0 mid-count holds the counter
        bus.SI = 1'b0;
        shifts(3, 0, "pre_en_done");
        bus.EN = 1'b0;
        for (int i = 0; i < 2; i++) begin step(); chk("en0_done", 32'(bus.SHIFT_DONE), 32'h0); end
        bus.EN = 1'b1;
        shifts(5, 5, "en_resume_done");

        // MISR: impulse then zeros walks through the feedback
        bus.MODE = 2'b01; bus.D = 8'h00;
        step();
        chk("misr_init", 32'(bus.Q), 32'h00);
`ifdef SCAN_MISR_EN
        misr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
`else
        misr_exp = '{default: 8'h00};
`endif
        bus.MODE = 2'b11;
        for (int i = 0; i < 9; i++) begin
            bus.D = (i == 0) ? 8'h01 : 8'h00;
            step();
            chk("misr_q", 32'(bus.Q), 32'(misr_exp[i]));
            chk("misr_done", 32'(bus.SHIFT_DONE), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
